ps2_key_decoder: RTL

Upstream front end of the typing game: receives raw PS/2 keyboard frames, decodes Set-2 scancodes into the game's 5-bit letter code, and drives `keystroke` / `keyReleased` into `PlayerActivity`. It also reports when a key is pressed or released and flags bad frames. Everything downstream sees only synchronous, single-clock signals.

---
 rtl/ps2_pkg.sv | 53 +++++
 rtl/ps2_rx_frame.sv | 118 +++++++++++
 rtl/ps2_key_decoder.sv | 112 +++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, types and the Set-2 scancode to letter map for the PS/2 front end.
package ps2_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    typedef logic [4:0] letter_t;

    localparam letter_t KEY_NONE  = 5'd0;
    localparam letter_t KEY_OTHER = 5'd31;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StCheck
    } rx_state_t;

    // Set-2 make code to letter code (a=1 .. z=26); everything else is KEY_OTHER.
    function automatic letter_t scan_to_letter(input logic [7:0] code);
        letter_t l;
        case (code)
            8'h1C:   l = 5'd1;   // a
            8'h32:   l = 5'd2;   // b
            8'h21:   l = 5'd3;   // c
            8'h23:   l = 5'd4;   // d
            8'h24:   l = 5'd5;   // e
            8'h2B:   l = 5'd6;   // f
            8'h34:   l = 5'd7;   // g
            8'h33:   l = 5'd8;   // h
            8'h43:   l = 5'd9;   // i
            8'h3B:   l = 5'd10;  // j
            8'h42:   l = 5'd11;  // k
            8'h4B:   l = 5'd12;  // l
            8'h3A:   l = 5'd13;  // m
            8'h31:   l = 5'd14;  // n
            8'h44:   l = 5'd15;  // o
            8'h4D:   l = 5'd16;  // p
            8'h15:   l = 5'd17;  // q
            8'h2D:   l = 5'd18;  // r
            8'h1B:   l = 5'd19;  // s
            8'h2C:   l = 5'd20;  // t
            8'h3C:   l = 5'd21;  // u
            8'h2A:   l = 5'd22;  // v
            8'h1D:   l = 5'd23;  // w
            8'h22:   l = 5'd24;  // x
            8'h35:   l = 5'd25;  // y
            8'h1A:   l = 5'd26;  // z
            default: l = KEY_OTHER;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: input synchronizers, falling-edge detect, 11-bit frame FSM and
// mid-frame timeout. o_rx_valid / o_rx_err are single-cycle pulses driven from CHECK
// (or from the timeout) so the top level can register them one cycle later.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_valid,
    output logic       o_rx_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_clk_prev;
    rx_state_t              r_state;
    rx_state_t              w_state_d;
    logic [9:0]             r_shift;
    logic [9:0]             w_shift_d;
    logic [3:0]             r_bit_cnt;
    logic [3:0]             w_bit_cnt_d;
    logic [TW-1:0]          r_timer;
    logic [TW-1:0]          w_timer_d;

    logic w_clk_s;
    logic w_data_s;
    logic w_fall;
    logic w_frame_ok;

    assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
    assign w_data_s = r_data_sync[SYNC_STAGES-1];
    assign w_fall   = r_clk_prev & ~w_clk_s;

    // After 10 shifts: [7:0] data, [8] parity, [9] stop. Odd parity over data+parity.
    assign w_frame_ok = r_shift[9] & (^r_shift[8:0]);
    assign o_rx_byte  = r_shift[7:0];

    // Synchronizers reset to the idle-high line level so reset never fakes an edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_ps2_data};
            r_clk_prev  <= w_clk_s;
        end
    end

    // Frame FSM state, shift register, bit counter and idle timer.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= StIdle;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_timer   <= '0;
        end else begin
            r_state   <= w_state_d;
            r_shift   <= w_shift_d;
            r_bit_cnt <= w_bit_cnt_d;
            r_timer   <= w_timer_d;
        end
    end

    // Next-state: start bit in IDLE, 10 bits in SHIFT, verdict in CHECK.
    always_comb begin
        w_state_d   = r_state;
        w_shift_d   = r_shift;
        w_bit_cnt_d = r_bit_cnt;
        w_timer_d   = r_timer;
        o_rx_valid  = 1'b0;
        o_rx_err    = 1'b0;
        case (r_state)
            StIdle: begin
                w_bit_cnt_d = '0;
                w_timer_d   = '0;
                // A falling edge with data high is line noise: ignore silently.
                if (w_fall && !w_data_s) begin
                    w_state_d = StShift;
                end
            end
            StShift: begin
                if (w_fall) begin
                    w_shift_d   = {w_data_s, r_shift[9:1]};
                    w_bit_cnt_d = r_bit_cnt + 4'd1;
                    w_timer_d   = '0;
                    if (r_bit_cnt == 4'd9) begin
                        w_state_d = StCheck;
                    end
                end else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    o_rx_err  = 1'b1;
                    w_state_d = StIdle;
                end else begin
                    w_timer_d = r_timer + 1'b1;
                end
            end
            StCheck: begin
                if (w_frame_ok) begin
                    o_rx_valid = 1'b1;
                end else begin
                    o_rx_err = 1'b1;
                end
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: frame receiver plus Set-2 scancode decoder producing the game's
// 5-bit letter code and press/release status. Define PS2_TYPEMATIC_EN to let repeated make
// codes of the held key pulse o_keyValid; by default repeats are suppressed.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [4:0] o_keystroke,
    output logic       o_keyReleased,
    output logic       o_keyValid,
    output logic       o_frameError
);

    logic [7:0] w_rx_byte;
    logic       w_rx_valid;
    logic       w_rx_err;

    letter_t r_keystroke;
    letter_t w_keystroke_d;
    logic    r_released;
    logic    w_released_d;
    logic    r_valid;
    logic    w_valid_d;
    logic    r_err;
    logic    r_ext;
    logic    w_ext_d;
    logic    r_brk;
    logic    w_brk_d;
    letter_t w_code;

    ps2_rx_frame #(
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_ps2_clk  (i_ps2_clk),
        .i_ps2_data (i_ps2_data),
        .o_rx_byte  (w_rx_byte),
        .o_rx_valid (w_rx_valid),
        .o_rx_err   (w_rx_err)
    );

    assign w_code        = scan_to_letter(w_rx_byte);
    assign o_keystroke   = r_keystroke;
    assign o_keyReleased = r_released;
    assign o_keyValid    = r_valid;
    assign o_frameError  = r_err;

    // Output registers and prefix flags.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_keystroke <= KEY_NONE;
            r_released  <= 1'b1;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
        end else begin
            r_keystroke <= w_keystroke_d;
            r_released  <= w_released_d;
            r_valid     <= w_valid_d;
            r_err       <= w_rx_err;
            r_ext       <= w_ext_d;
            r_brk       <= w_brk_d;
        end
    end

    // Scancode decode: prefixes set flags, any other byte is acted on and clears them.
    always_comb begin
        w_keystroke_d = r_keystroke;
        w_released_d  = r_released;
        w_valid_d     = 1'b0;
        w_ext_d       = r_ext;
        w_brk_d       = r_brk;
        if (w_rx_valid) begin
            if (w_rx_byte == SC_EXT) begin
                w_ext_d = 1'b1;
            end else if (w_rx_byte == SC_BREAK) begin
                w_brk_d = 1'b1;
            end else begin
                w_ext_d = 1'b0;
                w_brk_d = 1'b0;
                if (!r_ext) begin
                    if (r_brk) begin
                        if (w_code == r_keystroke) begin
                            w_released_d = 1'b1;
                        end
                    end else if (w_code == r_keystroke && !r_released) begin
                        // Typematic repeat of the held key.
`ifdef PS2_TYPEMATIC_EN
                        w_valid_d = 1'b1;
`else
                        w_valid_d = 1'b0;
`endif
                    end else begin
                        w_keystroke_d = w_code;
                        w_released_d  = 1'b0;
                        w_valid_d     = 1'b1;
                    end
                end
            end
        end
    end

endmodule
